// File: rtl/gray_point_op.sv
// gray_point_op: two-stage point operation on a luminance pixel stream (bypass, invert, binarize, offset).
// Define GRAY_POINT_OP_STATS_EN to add a per-frame pixel counter reported on stat_pix_cnt.
module gray_point_op #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_Y,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_thresh,
    input  logic [DATA_W:0]   cfg_offset,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y
`ifdef GRAY_POINT_OP_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_pix_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_INVERT   = 2'd1,
        MODE_BINARIZE = 2'd2,
        MODE_OFFSET   = 2'd3
    } mode_e;

    logic                     vsyncPrev_q;
    mode_e                    mode_q;
    logic [DATA_W-1:0]        thresh_q;
    logic [DATA_W:0]          offset_q;

    logic                     s1Vsync_q;
    logic                     s1Href_q;
    logic                     s1Clken_q;
    logic [DATA_W-1:0]        s1Y_q;

    logic                     cfgLoad;
    mode_e                    modeEff;
    logic [DATA_W-1:0]        threshEff;
    logic [DATA_W:0]          offsetEff;
    logic signed [DATA_W+1:0] sum;
    logic [DATA_W-1:0]        pixel_d;

    // On the vsync rising edge the incoming cfg is used directly so the frame's first pixel sees it.
    always_comb begin
        cfgLoad   = per_frame_vsync & ~vsyncPrev_q;
        modeEff   = cfgLoad ? mode_e'(cfg_mode) : mode_q;
        threshEff = cfgLoad ? cfg_thresh : thresh_q;
        offsetEff = cfgLoad ? cfg_offset : offset_q;
        sum       = $signed({2'b00, per_img_Y}) + $signed({offsetEff[DATA_W], offsetEff});
        pixel_d   = '0;
        if (per_frame_clken) begin
            case (modeEff)
                MODE_BYPASS:   pixel_d = per_img_Y;
                MODE_INVERT:   pixel_d = ~per_img_Y;
                MODE_BINARIZE: pixel_d = (per_img_Y >= threshEff) ? '1 : '0;
                MODE_OFFSET: begin
                    if (sum[DATA_W+1])
                        pixel_d = '0;
                    else if (sum[DATA_W])
                        pixel_d = '1;
                    else
                        pixel_d = sum[DATA_W-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsyncPrev_q <= 1'b0;
            mode_q      <= MODE_BYPASS;
            thresh_q    <= '0;
            offset_q    <= '0;
        end else begin
            vsyncPrev_q <= per_frame_vsync;
            if (cfgLoad) begin
                mode_q   <= mode_e'(cfg_mode);
                thresh_q <= cfg_thresh;
                offset_q <= cfg_offset;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Vsync_q        <= 1'b0;
            s1Href_q         <= 1'b0;
            s1Clken_q        <= 1'b0;
            s1Y_q            <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= '0;
        end else begin
            s1Vsync_q        <= per_frame_vsync;
            s1Href_q         <= per_frame_href;
            s1Clken_q        <= per_frame_clken;
            s1Y_q            <= pixel_d;
            post_frame_vsync <= s1Vsync_q;
            post_frame_href  <= s1Href_q;
            post_frame_clken <= s1Clken_q;
            post_img_Y       <= s1Y_q;
        end
    end

`ifdef GRAY_POINT_OP_STATS_EN
    logic [CNT_W-1:0] pixCnt_q;
    logic [CNT_W-1:0] stat_q;
    logic             postVsyncPrev_q;

    // Counts output pixels; the falling edge of post vsync publishes the total and restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixCnt_q        <= '0;
            stat_q          <= '0;
            postVsyncPrev_q <= 1'b0;
        end else begin
            postVsyncPrev_q <= post_frame_vsync;
            if (postVsyncPrev_q && !post_frame_vsync) begin
                stat_q   <= pixCnt_q;
                pixCnt_q <= '0;
            end else if (post_frame_vsync && post_frame_clken && (pixCnt_q != '1)) begin
                pixCnt_q <= pixCnt_q + CNT_W'(1);
            end
        end
    end

    assign stat_pix_cnt = stat_q;
`endif

endmodule

// File: tb/tb_gray_point_op.sv
// tb_gray_point_op: randomized frames against an arithmetic reference model with a per-cycle scoreboard.
// Stats checks are compiled in only when GRAY_POINT_OP_STATS_EN is defined.
module tb_gray_point_op;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 24;
    localparam int PIX_MAX = 255;

    logic              clk;
    logic              rst_n;
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [DATA_W-1:0] per_img_Y;
    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_thresh;
    logic [DATA_W:0]   cfg_offset;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic              post_frame_clken;
    logic [DATA_W-1:0] post_img_Y;
`ifdef GRAY_POINT_OP_STATS_EN
    logic [CNT_W-1:0]  stat_pix_cnt;
`endif

    gray_point_op #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .cfg_mode         (cfg_mode),
        .cfg_thresh       (cfg_thresh),
        .cfg_offset       (cfg_offset),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y)
`ifdef GRAY_POINT_OP_STATS_EN
        ,
        .stat_pix_cnt     (stat_pix_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       h;
        logic       c;
        logic [7:0] y;
    } rec_t;

    rec_t       expQ[$];
    logic [7:0] pixList[$];
    int         checksTotal  = 0;
    int         checksPassed = 0;

    int mdlPrevVsync = 0;
    int shMode       = 0;
    int shThresh     = 0;
    int shOffset     = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp)
            checksPassed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] refPixel(input int y, input int mode, input int th, input int off);
        int s;
        case (mode)
            0: return 8'(y);
            1: return 8'(PIX_MAX - y);
            2: return (y >= th) ? 8'(PIX_MAX) : 8'd0;
            default: begin
                s = y + off;
                if (s < 0) s = 0;
                if (s > PIX_MAX) s = PIX_MAX;
                return 8'(s);
            end
        endcase
    endfunction

    // Drives one cycle and records what the outputs must show two edges later.
    task automatic applyStimulus(input logic v, input logic h, input logic c, input logic [7:0] y,
                                 input logic rstN);
        rec_t r;
        per_frame_vsync = v;
        per_frame_href  = h;
        per_frame_clken = c;
        per_img_Y       = y;
        rst_n           = rstN;
        r = '0;
        if (!rstN) begin
            mdlPrevVsync = 0;
            shMode       = 0;
            shThresh     = 0;
            shOffset     = 0;
            if (expQ.size() > 0) expQ[expQ.size()-1] = '0;
            expQ.push_back(r);
        end else begin
            if (v && mdlPrevVsync == 0) begin
                shMode   = int'(cfg_mode);
                shThresh = int'(cfg_thresh);
                shOffset = int'(cfg_offset) - (cfg_offset[8] ? 512 : 0);
            end
            mdlPrevVsync = v ? 1 : 0;
            r.v = v;
            r.h = h;
            r.c = c;
            r.y = c ? refPixel(int'(y), shMode, shThresh, shOffset) : 8'd0;
            expQ.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic randomizeCfg();
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_thresh = 8'($urandom);
        cfg_offset = 9'($urandom);
    endtask

    task automatic runFrame(input int nLines, input int nPix, input logic [1:0] mode,
                            input logic [7:0] th, input logic [8:0] off, input bit churn,
                            input int rstAt);
        int         cyc;
        logic [7:0] y;
        cyc        = 0;
        cfg_mode   = mode;
        cfg_thresh = th;
        cfg_offset = off;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, cyc != rstAt);
            cyc++;
        end
        for (int l = 0; l < nLines; l++) begin
            for (int p = 0; p < nPix; p++) begin
                if (churn) randomizeCfg();
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom), cyc != rstAt);
                    cyc++;
                end
                y = (pixList.size() > 0) ? pixList.pop_front() : 8'($urandom);
                applyStimulus(1'b1, 1'b1, 1'b1, y, cyc != rstAt);
                cyc++;
            end
            for (int i = 0; i < 2; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, cyc != rstAt);
                cyc++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef GRAY_POINT_OP_STATS_EN
            if (i == 2 && rstAt < 0)
                checkOutput("stat_pix_cnt", 32'(stat_pix_cnt), 32'(nLines * nPix));
`endif
        end
    endtask

    // Scoreboard monitor: one expected record retires per clock, sampled just after the edge.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL queue_underflow: got no expectation, expected one at %0t", $time);
            end else begin
                r = expQ.pop_front();
                checkOutput("sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}),
                            32'({r.v, r.h, r.c}));
                checkOutput("post_img_Y", 32'(post_img_Y), 32'(r.y));
            end
        end
    end

    initial begin
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Y       = '0;
        cfg_mode        = '0;
        cfg_thresh      = '0;
        cfg_offset      = '0;
        rst_n           = 1'b0;
        expQ.push_back('0);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        pixList.push_back(8'h00);
        pixList.push_back(8'h3C);
        runFrame(1, 2, 2'd1, 8'h00, 9'd0, 1'b0, -1);

        pixList.push_back(8'h7F);
        pixList.push_back(8'h80);
        pixList.push_back(8'hFF);
        runFrame(1, 3, 2'd2, 8'h80, 9'd0, 1'b0, -1);

        pixList.push_back(8'd200);
        runFrame(1, 1, 2'd3, 8'h00, 9'd100, 1'b0, -1);

        pixList.push_back(8'd30);
        pixList.push_back(8'd80);
        runFrame(1, 2, 2'd3, 8'h00, 9'h1CE, 1'b0, -1);

        runFrame(2, 4, 2'd2, 8'h00, 9'd0, 1'b0, -1);
        runFrame(3, 5, 2'd0, 8'h00, 9'd0, 1'b1, -1);
        runFrame(2, 5, 2'd1, 8'h00, 9'd0, 1'b0, -1);
        runFrame(3, 6, 2'd1, 8'h40, 9'd20, 1'b0, 12);
        runFrame(2, 4, 2'd0, 8'h00, 9'd0, 1'b0, -1);
        runFrame(4, 6, 2'd3, 8'h00, 9'h1F0, 1'b0, -1);

        for (int f = 0; f < 6; f++)
            runFrame(int'($urandom_range(1, 4)), int'($urandom_range(2, 8)),
                     2'($urandom_range(0, 3)), 8'($urandom), 9'($urandom), 1'b1, -1);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/gray_point_op.md
GRAY_POINT_OP -- requirements
Module: gray_point_op

Interface
REQ-001 Parameter DATA_W, default 8, pixel bit width (legal 4..16).
REQ-002 Parameter CNT_W, default 24, width of the statistics counter.
REQ-003 clk  input  1  cmos video pixel clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 per_frame_vsync  input  1  frame valid, high during a frame.
REQ-006 per_frame_href  input  1  line valid.
REQ-007 per_frame_clken  input  1  pixel valid strobe.
REQ-008 per_img_Y  input  DATA_W  input luminance.
REQ-009 cfg_mode  input  2  0 bypass, 1 invert, 2 binarize, 3 offset.
REQ-010 cfg_thresh  input  DATA_W  binarize threshold.
REQ-011 cfg_offset  input  DATA_W+1  signed two's-complement brightness offset.
REQ-012 post_frame_vsync  output  1  delayed vsync.
REQ-013 post_frame_href  output  1  delayed href.
REQ-014 post_frame_clken  output  1  delayed clken.
REQ-015 post_img_Y  output  DATA_W  processed luminance.
REQ-016 stat_pix_cnt  output  CNT_W  pixels in last completed frame (only with GRAY_POINT_OP_STATS_EN).

Function
REQ-017 Pipeline SHALL advance every clk; fixed latency 2 cycles for data, vsync, href and clken alike.
REQ-018 Stage 1 SHALL register the per_* syncs and the computed pixel; stage 2 SHALL register both again to the post_* outputs.
REQ-019 Shadow config (mode, thresh, offset) SHALL load from cfg_* only in the cycle where per_frame_vsync is 1 and its registered previous value is 0.
REQ-020 cfg_* changes mid-frame SHALL NOT affect any pixel until the next vsync rising edge.
REQ-021 Mode 0: out = in.
REQ-022 Mode 1: out = (2^DATA_W-1) - in.
REQ-023 Mode 2: out = 2^DATA_W-1 if in >= thresh, else 0; thresh = 0 gives all-max.
REQ-024 Mode 3: sum = in + offset, computed signed in DATA_W+2 bits.
REQ-025 Mode 3 clamping: sum < 0 gives 0; sum > 2^DATA_W-1 gives 2^DATA_W-1.
REQ-026 post_img_Y SHALL be 0 whenever post_frame_clken is 0.
REQ-027 Vsync rising edge on the same cycle as a cfg change SHALL capture the new cfg; the first pixel of that frame uses it.

Reset
REQ-028 While rst_n=0 at a clk edge: all pipeline registers, post_* outputs and stat_pix_cnt SHALL be 0.
REQ-029 While rst_n=0 at a clk edge: shadow mode SHALL be 0 (bypass), thresh 0, offset 0, edge-detect register 0.
REQ-030 Reset asserted mid-frame SHALL take effect next edge, discarding in-flight pixels.
REQ-031 If vsync is already high when reset releases, it SHALL be treated as a rising edge.

Configuration
REQ-032 Macro GRAY_POINT_OP_STATS_EN defined: an internal counter SHALL increment on each post_frame_clken=1 while post_frame_vsync=1.
REQ-033 The counter SHALL saturate at 2^CNT_W-1.
REQ-034 On post_frame_vsync falling edge, the counter value including that cycle's pixel SHALL be copied to stat_pix_cnt and the counter cleared.
REQ-035 Macro undefined: port stat_pix_cnt and the counter SHALL be absent.

Verification
REQ-036 DATA_W=8, mode 1 latched, pixel 0x00 then 0x3C with clken=1 -> post_img_Y 0xFF then 0xC3, two cycles later.
REQ-037 Mode 2, thresh 0x80, pixels 0x7F,0x80,0xFF -> 0x00,0xFF,0xFF.
REQ-038 Mode 3, offset +100 on pixel 200 -> 255; offset -50 on pixel 30 -> 0; offset -50 on pixel 80 -> 30.
REQ-039 Mode switched 0->1 mid-frame -> remaining pixels of that frame unchanged; next frame inverted.
REQ-040 rst_n low for 1 cycle mid-line -> all post_* 0 next cycle; next frame processed as bypass until new cfg latched.
REQ-041 STATS_EN, frame of 4 lines x 6 clken pixels -> stat_pix_cnt = 24 one cycle after post_frame_vsync falls.
